// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU/monitor requesters, the memory arbiter and the single-port memory.
// The arbiter uses the slave modport; the requester/memory environment uses master.
interface mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
) ();
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic          cpu_stall;

    logic          mon_req;
    logic          mon_we;
    logic [AW-1:0] mon_addr;
    logic [DW-1:0] mon_wdata;
    logic          mon_ack;

    logic [DW-1:0] rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  mon_req, mon_we, mon_addr, mon_wdata,
        input  mem_rdata,
        output cpu_ack, cpu_stall, mon_ack, rdata,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output mon_req, mon_we, mon_addr, mon_wdata,
        output mem_rdata,
        input  cpu_ack, cpu_stall, mon_ack, rdata,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between CPU and debug monitor: IDLE -> GNT -> DONE, monitor priority
// with a burst cap. Optional stall_cycles counter enabled by MEM_ARB_STALL_CNT_EN.
module mem_arbiter #(
    parameter int AW            = 8,
    parameter int DW            = 8,
    parameter int MON_BURST_MAX = 4
) (
    input  logic          clock,
    input  logic          reset_n,
`ifdef MEM_ARB_STALL_CNT_EN
    output logic [15:0]   stall_cycles,
`endif
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GNT  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_MON = 1'b1;

    localparam logic [3:0] BURST_MAX = 4'(MON_BURST_MAX);

    logic [1:0]    r_state;
    logic          r_owner;
    logic [3:0]    r_burst_cnt;
    logic          r_is_write;
    logic          r_cpu_ack;
    logic          r_mon_ack;
    logic [DW-1:0] r_rdata;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_mem_we;

    logic          w_mon_win;
    logic [3:0]    w_burst_inc;
    logic          w_cpu_stall;

    assign w_mon_win   = bus.mon_req && (!bus.cpu_req || (r_burst_cnt < BURST_MAX));
    assign w_burst_inc = (r_burst_cnt >= BURST_MAX) ? BURST_MAX : r_burst_cnt + 4'd1;
    assign w_cpu_stall = bus.cpu_req & ~r_cpu_ack;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_owner     <= OWN_CPU;
            r_burst_cnt <= '0;
            r_is_write  <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_mon_ack   <= 1'b0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_mon_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_mon_win) begin
                        r_owner     <= OWN_MON;
                        r_burst_cnt <= bus.cpu_req ? w_burst_inc : 4'd0;
                        r_mem_addr  <= bus.mon_addr;
                        r_mem_wdata <= bus.mon_wdata;
                        r_mem_we    <= bus.mon_we;
                        r_is_write  <= bus.mon_we;
                        r_state     <= S_GNT;
                    end else if (bus.cpu_req) begin
                        r_owner     <= OWN_CPU;
                        r_burst_cnt <= '0;
                        r_mem_addr  <= bus.cpu_addr;
                        r_mem_wdata <= bus.cpu_wdata;
                        r_mem_we    <= bus.cpu_we;
                        r_is_write  <= bus.cpu_we;
                        r_state     <= S_GNT;
                    end else begin
                        r_mem_we    <= 1'b0;
                    end
                end
                S_GNT: begin
                    r_mem_we <= 1'b0;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    // Ack is registered here so it is visible in the cycle IDLE re-evaluates.
                    if (!r_is_write) r_rdata <= bus.mem_rdata;
                    r_cpu_ack <= (r_owner == OWN_CPU);
                    r_mon_ack <= (r_owner == OWN_MON);
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_mem_we <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.mon_ack   = r_mon_ack;
    assign bus.cpu_stall = w_cpu_stall;
    assign bus.rdata     = r_rdata;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_we    = r_mem_we;

`ifdef MEM_ARB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (w_cpu_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`else
    // Stall counter not built; stall visibility is through cpu_stall only.
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard of expected acks (owner + rdata) popped on each ack.
module tb_mem_arbiter;

    typedef struct packed {
        logic       is_mon;
        logic [7:0] rdata;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    mem_arbiter_if #(.AW(8), .DW(8)) bus ();

`ifdef MEM_ARB_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    mem_arbiter #(.AW(8), .DW(8), .MON_BURST_MAX(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
`ifdef MEM_ARB_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .bus          (bus)
    );

    // Synchronous single-port memory with a preload path for the bench.
    logic [7:0] tb_mem [256];
    logic       pre_en = 1'b0;
    logic [7:0] pre_addr = '0;
    logic [7:0] pre_data = '0;
    always @(posedge clock) begin
        if (pre_en) tb_mem[pre_addr] <= pre_data;
        else if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= tb_mem[bus.mem_addr];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

`ifdef MEM_ARB_STALL_CNT_EN
    int tb_stall = 0;
    always @(posedge clock) if (reset_n && bus.cpu_req && !bus.cpu_ack) tb_stall <= tb_stall + 1;
`endif

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [7:0] mdl_mem [256];
    logic [7:0] mdl_rdata = '0;
    int cpu_left = 0;
    int mon_left = 0;
    int last_ack_cyc = 0;
    int gap = 0;
    int we_cycles = 0;
    logic ack_now = 1'b0;

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clock);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clock); #1;
        pre_en = 1'b0;
        mdl_mem[a] = d;
    endtask

    task automatic exp_read(input logic is_mon, input logic [7:0] a);
        sb.push_back('{is_mon: is_mon, rdata: mdl_mem[a]});
        mdl_rdata = mdl_mem[a];
    endtask

    task automatic exp_write(input logic is_mon, input logic [7:0] a, input logic [7:0] d);
        sb.push_back('{is_mon: is_mon, rdata: mdl_rdata});
        mdl_mem[a] = d;
    endtask

    // Scoreboard consumer: one clock, pop and compare on any ack, release requesters when done.
    task automatic sb_step();
        exp_t e;
        ack_now = 1'b0;
        @(negedge clock);
        if (bus.mem_we === 1'b1) we_cycles++;
        if (bus.cpu_ack === 1'b1 || bus.mon_ack === 1'b1) begin
            ack_now = 1'b1;
            gap = cyc - last_ack_cyc;
            last_ack_cyc = cyc;
            checks++;
            if (bus.cpu_ack === 1'b1 && bus.mon_ack === 1'b1) begin
                errors++;
                $display("FAIL ack_overlap: cpu_ack=1 mon_ack=1 at cycle %0d, required at most one ack", cyc);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: cpu_ack=%b mon_ack=%b at cycle %0d, required no ack", bus.cpu_ack, bus.mon_ack, cyc);
            end else begin
                e = sb.pop_front();
                if (bus.mon_ack !== e.is_mon || bus.rdata !== e.rdata)
                begin
                    errors++;
                    $display("FAIL sb_ack: got mon_ack=%b rdata=%h, required mon_ack=%b rdata=%h (cycle %0d)",
                             bus.mon_ack, bus.rdata, e.is_mon, e.rdata, cyc);
                end
            end
            if (bus.cpu_ack === 1'b1 && cpu_left > 0) begin
                cpu_left--;
                if (cpu_left == 0) bus.cpu_req = 1'b0;
            end
            if (bus.mon_ack === 1'b1 && mon_left > 0) begin
                mon_left--;
                if (mon_left == 0) bus.mon_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.mon_req = 1'b0; bus.mon_we = 1'b0; bus.mon_addr = '0; bus.mon_wdata = '0;
        repeat (2) @(negedge clock);
        checks += 7;
        if (bus.cpu_ack !== 1'b0)    begin errors++; $display("FAIL rst_cpu_ack: got %b required 0", bus.cpu_ack); end
        if (bus.mon_ack !== 1'b0)    begin errors++; $display("FAIL rst_mon_ack: got %b required 0", bus.mon_ack); end
        if (bus.mem_we !== 1'b0)     begin errors++; $display("FAIL rst_mem_we: got %b required 0", bus.mem_we); end
        if (bus.mem_addr !== 8'h00)  begin errors++; $display("FAIL rst_mem_addr: got %h required 00", bus.mem_addr); end
        if (bus.mem_wdata !== 8'h00) begin errors++; $display("FAIL rst_mem_wdata: got %h required 00", bus.mem_wdata); end
        if (bus.rdata !== 8'h00)     begin errors++; $display("FAIL rst_rdata: got %h required 00", bus.rdata); end
        if (bus.cpu_stall !== 1'b0)  begin errors++; $display("FAIL rst_cpu_stall: got %b required 0", bus.cpu_stall); end
        reset_n = 1'b1;
        mdl_rdata = '0;
    endtask

    task automatic test_cpu_read();
        int start;
        int stall_n;
        preload(8'h10, 8'hA5);
        preload(8'h30, 8'h5A);
        @(posedge clock); #1;
        start = cyc;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h10;
        cpu_left = 1;
        exp_read(1'b0, 8'h10);
        stall_n = 0;
        for (int i = 0; i < 4; i++) begin
            sb_step();
            if (bus.cpu_stall === 1'b1) stall_n++;
            if (i == 1) begin
                checks++;
                if (bus.mem_addr !== 8'h10 || bus.mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL read_grant: got mem_addr=%h mem_we=%b, required 10/0", bus.mem_addr, bus.mem_we);
                end
            end
        end
        checks += 3;
        if (last_ack_cyc != start + 3) begin errors++; $display("FAIL read_latency: ack at cycle %0d, required %0d", last_ack_cyc, start + 3); end
        if (stall_n != 3) begin errors++; $display("FAIL read_stall: stall cycles %0d, required 3", stall_n); end
        if (sb.size() != 0) begin errors++; $display("FAIL read_done: %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_mon_write_cpu_read();
        logic [7:0] w_addr;
        logic [7:0] w_data;
        w_addr = '0; w_data = '0;
        @(posedge clock); #1;
        bus.mon_req = 1'b1; bus.mon_we = 1'b1; bus.mon_addr = 8'h20; bus.mon_wdata = 8'h3C;
        mon_left = 1;
        exp_write(1'b1, 8'h20, 8'h3C);
        we_cycles = 0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            sb_step();
            if (bus.mem_we === 1'b1) begin w_addr = bus.mem_addr; w_data = bus.mem_wdata; end
        end
        checks += 3;
        if (sb.size() != 0) begin errors++; $display("FAIL mon_write_done: %0d pending, required 0", sb.size()); end
        if (we_cycles != 1) begin errors++; $display("FAIL mon_write_we: mem_we high %0d cycles, required 1", we_cycles); end
        if (w_addr !== 8'h20 || w_data !== 8'h3C) begin
            errors++; $display("FAIL mon_write_bus: got addr=%h data=%h, required 20/3C", w_addr, w_data);
        end
        @(posedge clock); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h20;
        cpu_left = 1;
        exp_read(1'b0, 8'h20);
        we_cycles = 0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) sb_step();
        checks += 2;
        if (sb.size() != 0) begin errors++; $display("FAIL cpu_read_done: %0d pending, required 0", sb.size()); end
        if (we_cycles != 0) begin errors++; $display("FAIL cpu_read_we: mem_we high %0d cycles, required 0", we_cycles); end
    endtask

    task automatic test_contention();
        int n_acks;
`ifdef MEM_ARB_STALL_CNT_EN
        int s0;
        int t0;
`endif
        @(posedge clock); #1;
`ifdef MEM_ARB_STALL_CNT_EN
        s0 = int'(stall_cycles);
        t0 = tb_stall;
`endif
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h10;
        bus.mon_req = 1'b1; bus.mon_we = 1'b0; bus.mon_addr = 8'h30;
        cpu_left = 2;
        mon_left = 8;
        for (int r = 0; r < 2; r++) begin
            for (int m = 0; m < 4; m++) exp_read(1'b1, 8'h30);
            exp_read(1'b0, 8'h10);
        end
        n_acks = 0;
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            sb_step();
            if (ack_now) begin
                n_acks++;
                if (n_acks > 1) begin
                    checks++;
                    if (gap != 3) begin errors++; $display("FAIL contention_gap: ack spacing %0d, required 3", gap); end
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL contention_done: %0d pending, required 0", sb.size()); end
`ifdef MEM_ARB_STALL_CNT_EN
        checks++;
        if (int'(stall_cycles) - s0 != tb_stall - t0) begin
            errors++; $display("FAIL stall_count: got %0d, required %0d", int'(stall_cycles) - s0, tb_stall - t0);
        end
`endif
    endtask

    task automatic test_drop_mid();
        @(posedge clock); #1;
        bus.mon_req = 1'b1; bus.mon_we = 1'b0; bus.mon_addr = 8'h30;
        mon_left = 0;
        exp_read(1'b1, 8'h30);
        @(negedge clock);
        @(negedge clock);
        bus.mon_req = 1'b0;
        for (int i = 0; i < 10 && sb.size() != 0; i++) sb_step();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL drop_mid: %0d pending, required ack", sb.size()); end
    endtask

    task automatic test_reset_mid_gnt();
        @(posedge clock); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h40; bus.cpu_wdata = 8'h77;
        cpu_left = 0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL gnt_we: got %b required 1", bus.mem_we); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== 8'h00 || bus.mem_wdata !== 8'h00 ||
            bus.rdata !== 8'h00 || bus.cpu_ack !== 1'b0 || bus.mon_ack !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got we=%b addr=%h wdata=%h rdata=%h acks=%b%b, required all 0",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.rdata, bus.cpu_ack, bus.mon_ack);
        end
        bus.cpu_req = 1'b0;
        mdl_rdata = '0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h40; bus.cpu_wdata = 8'h88;
        cpu_left = 1;
        exp_write(1'b0, 8'h40, 8'h88);
        for (int i = 0; i < 20 && sb.size() != 0; i++) sb_step();
        @(posedge clock); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h40;
        cpu_left = 1;
        exp_read(1'b0, 8'h40);
        for (int i = 0; i < 20 && sb.size() != 0; i++) sb_step();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL post_reset: %0d pending, required 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_mon_write_cpu_read();
        test_contention();
        test_drop_mid();
        test_reset_mid_gnt();
        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port program/data memory between the CPU controller/datapath and the debug monitor.
- Grants one requester at a time through a 3-state sequencer with fixed transaction latency.
- Monitor has priority; a burst cap guarantees CPU progress.
- Drives cpu_stall so the CPU sequencer holds its state while its memory request is pending.

Parameters:
- AW, 8, address width
- DW, 8, data width
- MON_BURST_MAX, 4, max consecutive monitor grants while cpu_req pending (1..15)

Ports:
- clock  in  1  system clock; all flops on posedge
- reset_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  one-cycle pulse: CPU transaction done
- cpu_stall  out  1  high while cpu_req && !cpu_ack
- mon_req  in  1  monitor access request; held until mon_ack
- mon_we  in  1  monitor write/read
- mon_addr  in  AW  monitor address
- mon_wdata  in  DW  monitor write data
- mon_ack  out  1  one-cycle pulse: monitor transaction done
- rdata  out  DW  read data, valid in ack cycle, held until next ack
- mem_addr  out  AW  registered memory address
- mem_wdata  out  DW  registered memory write data
- mem_we  out  1  registered memory write enable
- mem_rdata  in  DW  synchronous memory read data (1 cycle after mem_addr)

Behaviour:
- Reset (async, reset_n=0): state=IDLE; cpu_ack=mon_ack=mem_we=0; mem_addr=0; mem_wdata=0; rdata=0; burst_cnt=0; owner=CPU.
- cpu_stall is combinational: cpu_req & ~cpu_ack.
- IDLE: evaluate requests at the posedge.
  - mon_req and (!cpu_req or burst_cnt<MON_BURST_MAX): owner=MON; burst_cnt+=1 if cpu_req, else burst_cnt=0.
  - Else if cpu_req: owner=CPU; burst_cnt=0.
  - Latch the owner's addr/wdata/we into mem_*; next state=GNT.
  - No request: stay in IDLE; mem_we=0.
- GNT: mem_* stable for one cycle (memory write occurs at this edge); mem_we cleared on exit; next state=DONE.
- DONE: rdata<=mem_rdata (latched for reads only; writes leave rdata unchanged); owner's ack pulses for exactly this cycle; next state=IDLE.
- Latency: req sampled at edge N → ack high for the cycle following edge N+2 → earliest re-grant at edge N+3. Throughput: one transaction per 3 cycles.
- Requester drops req in the cycle after ack. A req still high when IDLE evaluates is a new transaction.
- Request inputs are ignored in GNT/DONE. A request dropped mid-transaction does not abort; the transaction completes and ack still pulses.
- Simultaneous cpu_req and mon_req with burst_cnt=MON_BURST_MAX: CPU wins, and burst_cnt clears.
- burst_cnt saturates at MON_BURST_MAX; it never wraps.
- Reset asserted mid-transaction: immediate return to reset values; any write in GNT is not guaranteed.
- Undefined state encoding: recover to IDLE on the next edge.

Optional Feature:
- Macro MEM_ARB_STALL_CNT_EN.
- Defined: adds output stall_cycles[15:0].
  - Increments each clock where cpu_stall=1.
  - Saturates at 16'hFFFF.
  - Clears on reset.
  - Read by the monitor for performance display.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- CPU read only: preload mem[8'h10]=8'hA5; cpu_req=1, cpu_we=0, cpu_addr=8'h10 at edge 0 → cpu_ack pulse after edge 2, rdata=8'hA5, cpu_stall high 3 cycles.
- Monitor write then CPU read: mon write 8'h3C to 8'h20, then cpu read 8'h20 → mem_we high only in GNT, rdata=8'h3C in cpu_ack cycle.
- Contention: cpu_req and mon_req held continuously, MON_BURST_MAX=4 → grant order M,M,M,M,C,M,M,M,M,C; no ack overlap.
- Simultaneous first request (burst_cnt=0) → monitor granted first; CPU granted within 4 monitor transactions.
- Reset mid-GNT: reset_n=0 for 1 cycle during a CPU write → all outputs at reset values; next cpu_req completes normally.
- With MEM_ARB_STALL_CNT_EN: run the contention scenario for 30 cycles → stall_cycles equals the count of cycles where cpu_stall=1. Forced near 16'hFFFF, it stays at FFFF.
